// File: rtl/monty_pkg.sv
// Shared constants for the Montgomery datapath: operand split and multiplier latency.
package monty_pkg;

    localparam int unsigned Q_LEN_DEF = 64;
    localparam int unsigned FF_IN_DEF = 1;

    function automatic int unsigned half_w(input int unsigned q_len);
        return q_len / 2;
    endfunction

    function automatic int unsigned mul_lat(input int unsigned ff_in);
        return 3 + ff_in;
    endfunction

    localparam int unsigned H       = half_w(Q_LEN_DEF);
    localparam int unsigned MUL_LAT = mul_lat(FF_IN_DEF);

endpackage

// File: rtl/mul_half_reg.sv
// Registered unsigned W x W multiply producing a full 2W-bit product.
module mul_half_reg #(
    parameter int unsigned W = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic [2*W-1:0] p_o
);

    localparam int unsigned PW = 2 * W;

    logic [PW-1:0] p_d;
    logic [PW-1:0] p_q;

    assign p_d = PW'(a_i) * PW'(b_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p_o = p_q;

endmodule

// File: rtl/int_mul_pipe.sv
// Pipelined full-width unsigned multiplier built from four half-width products,
// with the modulus carried alongside so it lines up with the product.
module int_mul_pipe
    import monty_pkg::*;
#(
    parameter int unsigned Q_LEN = Q_LEN_DEF,
    parameter int unsigned K     = 2 * Q_LEN_DEF,
    parameter int unsigned FF_IN = FF_IN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [Q_LEN-1:0] A,
    input  logic [Q_LEN-1:0] B,
    input  logic [Q_LEN-1:0] q_in,
    output logic             out_valid,
    output logic [K-1:0]     C,
    output logic [Q_LEN-1:0] q_out
);

    localparam int unsigned HW  = half_w(Q_LEN);
    localparam int unsigned PW  = 2 * HW;
    localparam int unsigned MW  = PW + 1;
    localparam int unsigned LAT = mul_lat(FF_IN);

    logic [Q_LEN-1:0] a_s0;
    logic [Q_LEN-1:0] b_s0;

    // S0: optional input capture
    if (FF_IN != 0) begin : g_ff_in
        logic [Q_LEN-1:0] a_q;
        logic [Q_LEN-1:0] b_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                a_q <= '0;
                b_q <= '0;
            end else begin
                a_q <= A;
                b_q <= B;
            end
        end

        assign a_s0 = a_q;
        assign b_s0 = b_q;
    end else begin : g_no_ff_in
        assign a_s0 = A;
        assign b_s0 = B;
    end

    logic [PW-1:0] ll_s1;
    logic [PW-1:0] lh_s1;
    logic [PW-1:0] hl_s1;
    logic [PW-1:0] hh_s1;

    mul_half_reg #(.W(HW)) u_mul_ll (
        .clk (clk),
        .rst (rst),
        .a_i (a_s0[HW-1:0]),
        .b_i (b_s0[HW-1:0]),
        .p_o (ll_s1)
    );

    mul_half_reg #(.W(HW)) u_mul_lh (
        .clk (clk),
        .rst (rst),
        .a_i (a_s0[HW-1:0]),
        .b_i (b_s0[Q_LEN-1:HW]),
        .p_o (lh_s1)
    );

    mul_half_reg #(.W(HW)) u_mul_hl (
        .clk (clk),
        .rst (rst),
        .a_i (a_s0[Q_LEN-1:HW]),
        .b_i (b_s0[HW-1:0]),
        .p_o (hl_s1)
    );

    mul_half_reg #(.W(HW)) u_mul_hh (
        .clk (clk),
        .rst (rst),
        .a_i (a_s0[Q_LEN-1:HW]),
        .b_i (b_s0[Q_LEN-1:HW]),
        .p_o (hh_s1)
    );

    // S2: cross terms summed with their carry kept
    logic [MW-1:0] m_d;
    logic [MW-1:0] m_q;
    logic [PW-1:0] ll_q;
    logic [PW-1:0] hh_q;

    assign m_d = MW'(lh_s1) + MW'(hl_s1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q  <= '0;
            ll_q <= '0;
            hh_q <= '0;
        end else begin
            m_q  <= m_d;
            ll_q <= ll_s1;
            hh_q <= hh_s1;
        end
    end

    // S3: recombine; the result always fits in K = 2*Q_LEN bits
    logic [K-1:0] c_d;
    logic [K-1:0] c_q;

    assign c_d = (K'(hh_q) << Q_LEN) + (K'(m_q) << HW) + K'(ll_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q <= '0;
        end else begin
            c_q <= c_d;
        end
    end

    assign C = c_q;

    // Valid and modulus travel together through a delay line matching the data path
    for (genvar i = 0; i < LAT; i++) begin : g_dly
        logic             vld_d;
        logic             vld_q;
        logic [Q_LEN-1:0] q_d;
        logic [Q_LEN-1:0] q_q;

        if (i == 0) begin : g_head
            assign vld_d = in_valid;
            assign q_d   = q_in;
        end else begin : g_tail
            assign vld_d = g_dly[i-1].vld_q;
            assign q_d   = g_dly[i-1].q_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_q <= 1'b0;
                q_q   <= '0;
            end else begin
                vld_q <= vld_d;
                q_q   <= q_d;
            end
        end
    end

    assign out_valid = g_dly[LAT-1].vld_q;
    assign q_out     = g_dly[LAT-1].q_q;

endmodule

// File: tb/tb_int_mul_pipe.sv
// Bench for int_mul_pipe: default 64-bit instance plus a 52-bit instance without input registers.
module tb_int_mul_pipe;
    import monty_pkg::*;

    localparam int unsigned QL1  = 64;
    localparam int unsigned K1   = 128;
    localparam int unsigned QL2  = 52;
    localparam int unsigned K2   = 104;
    localparam int unsigned LAT1 = MUL_LAT;
    localparam int unsigned LAT2 = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    logic           v1 = 1'b0;
    logic [QL1-1:0] a1 = '0;
    logic [QL1-1:0] b1 = '0;
    logic [QL1-1:0] qi1 = '0;
    logic           ov1;
    logic [K1-1:0]  c1;
    logic [QL1-1:0] qo1;

    logic           v2 = 1'b0;
    logic [QL2-1:0] a2 = '0;
    logic [QL2-1:0] b2 = '0;
    logic [QL2-1:0] qi2 = '0;
    logic           ov2;
    logic [K2-1:0]  c2;
    logic [QL2-1:0] qo2;

    int_mul_pipe #(.Q_LEN(QL1), .K(K1), .FF_IN(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v1),
        .A         (a1),
        .B         (b1),
        .q_in      (qi1),
        .out_valid (ov1),
        .C         (c1),
        .q_out     (qo1)
    );

    int_mul_pipe #(.Q_LEN(QL2), .K(K2), .FF_IN(0)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v2),
        .A         (a2),
        .B         (b2),
        .q_in      (qi2),
        .out_valid (ov2),
        .C         (c2),
        .q_out     (qo2)
    );

    typedef struct {
        int unsigned  due;
        logic [127:0] c;
        logic [63:0]  q;
    } exp_t;

    typedef struct {
        logic [63:0]  a;
        logic [63:0]  b;
        logic [63:0]  q;
        logic [127:0] c;
    } vec_t;

    exp_t         eq1[$];
    exp_t         eq2[$];
    int           n_cmp = 0;
    int           n_bad = 0;
    int unsigned  cyc = 0;
    int           pulses1 = 0;
    int           pulses2 = 0;
    logic [127:0] x1 = '0;
    logic [127:0] x2 = '0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %h want %h", nm, cyc, got, want);
        end
    endtask

    // One clock: record issued inputs with their due cycle, then compare both outputs
    task automatic step();
        int unsigned cur;
        cur = cyc;
        if (v1 && !rst) eq1.push_back('{cur + LAT1, x1, qi1});
        if (v2 && !rst) eq2.push_back('{cur + LAT2, x2, 64'(qi2)});
        @(posedge clk);
        #1;
        cyc++;
        v1 = 1'b0;
        v2 = 1'b0;
        if (eq1.size() > 0 && eq1[0].due == cyc) begin
            chk("vld1", 128'(ov1), 128'(1));
            chk("c1", c1, eq1[0].c);
            chk("q1", 128'(qo1), 128'(eq1[0].q));
            void'(eq1.pop_front());
        end else begin
            chk("vld1_idle", 128'(ov1), 128'(0));
        end
        if (eq2.size() > 0 && eq2[0].due == cyc) begin
            chk("vld2", 128'(ov2), 128'(1));
            chk("c2", 128'(c2), eq2[0].c);
            chk("q2", 128'(qo2), 128'(eq2[0].q));
            void'(eq2.pop_front());
        end else begin
            chk("vld2_idle", 128'(ov2), 128'(0));
        end
        if (ov1) pulses1++;
        if (ov2) pulses2++;
        if (rst) begin
            chk("c1_rst", c1, 128'(0));
            chk("q1_rst", 128'(qo1), 128'(0));
            chk("c2_rst", 128'(c2), 128'(0));
            chk("q2_rst", 128'(qo2), 128'(0));
        end
    endtask

    task automatic issue1(input logic [63:0] a, input logic [63:0] b, input logic [63:0] q,
                          input logic [127:0] c);
        v1 = 1'b1; a1 = a; b1 = b; qi1 = q; x1 = c;
    endtask

    task automatic issue1_rnd();
        logic [63:0] a;
        logic [63:0] b;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        issue1(a, b, {$urandom, $urandom}, 128'(a) * 128'(b));
    endtask

    task automatic issue2(input logic [51:0] a, input logic [51:0] b, input logic [51:0] q,
                          input logic [127:0] c);
        v2 = 1'b1; a2 = a; b2 = b; qi2 = q; x2 = c;
    endtask

    task automatic issue2_rnd();
        logic [51:0] a;
        logic [51:0] b;
        a = 52'({$urandom, $urandom});
        b = 52'({$urandom, $urandom});
        issue2(a, b, 52'({$urandom, $urandom}), 128'(a) * 128'(b));
    endtask

    // Asynchronous reset: outputs must clear mid-cycle and in-flight work is dropped
    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        #1;
        chk("rst_vld1", 128'(ov1), 128'(0));
        chk("rst_c1", c1, 128'(0));
        chk("rst_q1", 128'(qo1), 128'(0));
        chk("rst_vld2", 128'(ov2), 128'(0));
        chk("rst_c2", 128'(c2), 128'(0));
        chk("rst_q2", 128'(qo2), 128'(0));
        eq1.delete();
        eq2.delete();
        repeat (ncyc) step();
        rst = 1'b0;
    endtask

    initial begin
        vec_t         tbl[8];
        logic [103:0] e52;
        logic [63:0]  sh;
        logic         pat[6];
        logic         obs[16];
        int           p0;

        sh = 64'(1) << H;
        tbl[0] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'h0123456789ABCDEF,
                   128'hFFFFFFFFFFFFFFFE0000000000000001};
        tbl[1] = '{sh, sh, 64'hFFFFFFFF00000001, 128'h10000000000000000};
        tbl[2] = '{64'h0, 64'hDEADBEEFCAFEBABE, 64'h1111, 128'h0};
        tbl[3] = '{64'h1, 64'hDEADBEEFCAFEBABE, 64'h2222, 128'hDEADBEEFCAFEBABE};
        tbl[4] = '{64'h8000000000000000, 64'h2, 64'h3333, 128'h10000000000000000};
        tbl[5] = '{64'hFFFFFFFF, 64'hFFFFFFFF, 64'h4444, 128'hFFFFFFFE00000001};
        tbl[6] = '{64'h8000000000000000, 64'h8000000000000000, 64'h5555,
                   128'h40000000000000000000000000000000};
        tbl[7] = '{64'hFFFFFFFFFFFFFFFF, 64'h2, 64'h6666, 128'h1FFFFFFFFFFFFFFFE};

        #1;
        do_reset(2);
        repeat (2) step();

        // Isolated all-ones product
        issue1(tbl[0].a, tbl[0].b, tbl[0].q, tbl[0].c);
        step();
        repeat (LAT1 + 1) step();

        // Directed table, back-to-back
        for (int i = 0; i < 8; i++) begin
            issue1(tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].c);
            step();
        end
        repeat (LAT1 + 1) step();

        // 52-bit instance, no input stage: (2^52-1)^2 = 2^104 - 2^53 + 1
        e52 = 104'(0) - (104'(1) << 53) + 104'(1);
        issue2(52'hFFFFFFFFFFFFF, 52'hFFFFFFFFFFFFF, 52'h123456789ABCD, 128'(e52));
        step();
        repeat (LAT2 + 1) step();

        // Bubble pattern must reappear unchanged on out_valid
        pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 16; k++) begin
            if (k < 6 && pat[k]) issue1_rnd();
            step();
            obs[k] = ov1;
        end
        for (int k = 0; k < int'(LAT1) - 1; k++) chk("bubble_lead", 128'(obs[k]), 128'(0));
        for (int k = 0; k < 6; k++) chk("bubble_pat", 128'(obs[k + int'(LAT1) - 1]), 128'(pat[k]));

        // 1000 back-to-back random operand pairs on both instances
        p0 = pulses1;
        pulses2 = 0;
        for (int i = 0; i < 1000; i++) begin
            issue1_rnd();
            issue2_rnd();
            step();
        end
        repeat (LAT1 + 2) step();
        chk("pulses1", 128'(pulses1 - p0), 128'(1000));
        chk("pulses2", 128'(pulses2), 128'(1000));

        // Reset two cycles after three issued inputs; nothing may emerge afterwards
        for (int i = 0; i < 3; i++) begin
            issue1_rnd();
            issue2_rnd();
            step();
        end
        repeat (2) step();
        do_reset(2);
        p0 = pulses1;
        repeat (8) step();
        chk("post_rst_quiet", 128'(pulses1 - p0), 128'(0));

        // Recovery after reset: first result after exactly the pipeline latency
        issue1(tbl[7].a, tbl[7].b, tbl[7].q, tbl[7].c);
        issue2_rnd();
        step();
        repeat (LAT1 + 1) step();

        chk("drain1", 128'(eq1.size()), 128'(0));
        chk("drain2", 128'(eq2.size()), 128'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
